// File: rtl/fine_sync_pkg.sv
// Shared definitions for the fine-sync lag correlator.
//   - state_t   : correlator control states
//   - FS_*      : default generics (sample width, lag, window, accumulator width)
//   - PROD_W    : width of one complex conjugate product component
package fine_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ACCUM,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int unsigned FS_DATA_W = 16;
  localparam int unsigned FS_LAG    = 64;
  localparam int unsigned FS_WIN    = 64;
  localparam int unsigned FS_ACC_W  = 40;

  // a_re*b_re + a_im*b_im needs one bit beyond the raw 2*DATA_W product.
  function automatic int unsigned prod_w(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

  localparam int unsigned PROD_W = prod_w(FS_DATA_W);

endpackage

// File: rtl/fine_sync_lag_correlator_if.sv
// Sample-in / correlation-out bundle for fine_sync_lag_correlator.
//   start                          : single-cycle request
//   in_re/in_im/in_valid/in_ready  : sample stream (valid/ready)
//   corr_re/corr_im/corr_valid/corr_ready : result (valid/ready)
//   busy                           : correlator not idle
// slave modport = correlator side, master modport = driver/consumer side.
interface fine_sync_lag_correlator_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40
);
  logic                     start;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  corr_re;
  logic signed [ACC_W-1:0]  corr_im;
  logic                     corr_valid;
  logic                     corr_ready;
  logic                     busy;

  modport slave (
    input  start, in_re, in_im, in_valid, corr_ready,
    output in_ready, corr_re, corr_im, corr_valid, busy
  );

  modport master (
    output start, in_re, in_im, in_valid, corr_ready,
    input  in_ready, corr_re, corr_im, corr_valid, busy
  );
endinterface

// File: rtl/fine_sync_delay_ram.sv
// LAG-deep circular delay line for packed {re,im} samples.
// Single port, synchronous read-before-write: when enabled, o_rdata returns
// the entry previously stored at i_addr while i_wdata overwrites it.
//   i_clk   : clock
//   i_en    : access enable (read and write together)
//   i_addr  : entry address
//   i_wdata : packed sample to store
//   o_rdata : old contents of i_addr, valid the cycle after i_en
module fine_sync_delay_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fine_sync_lag_correlator.sv
// Lag-LAG conjugate autocorrelation over a WIN-sample window:
//   C = sum x[n] * conj(x[n-LAG]), one result per start request.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : slave side of fine_sync_lag_correlator_if (start, sample
//            stream, result stream, busy)
// LAG must be a power of two (>= 2) so the write pointer wraps naturally.
module fine_sync_lag_correlator
  import fine_sync_pkg::*;
#(
  parameter int unsigned DATA_W = FS_DATA_W,
  parameter int unsigned LAG    = FS_LAG,
  parameter int unsigned WIN    = FS_WIN,
  parameter int unsigned ACC_W  = FS_ACC_W
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  fine_sync_lag_correlator_if.slave  bus
);

  localparam int unsigned PW    = prod_w(DATA_W);
  localparam int unsigned AW    = $clog2(LAG);
  localparam int unsigned CNT_W = $clog2((LAG > WIN) ? LAG : WIN) + 1;

  state_t r_state, w_next;

  logic                     r_in_ready;
  logic [AW-1:0]            r_wr_ptr;
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_accept;

  // stage 1: current sample a, RAM returns b = x[n-LAG]
  logic signed [DATA_W-1:0] r_a_re, r_a_im;
  logic                     r_s1_vld;
  logic [2*DATA_W-1:0]      w_rdata;
  logic signed [DATA_W-1:0] w_b_re, w_b_im;

  // stage 2: registered product
  logic signed [2*DATA_W-1:0] w_rr, w_ii, w_ir, w_ri;
  logic signed [PW-1:0]       w_p_re, w_p_im;
  logic signed [PW-1:0]       r_p_re, r_p_im;
  logic                       r_p_vld;

  logic signed [ACC_W-1:0]  r_acc_re, r_acc_im;
  logic                     w_busy, w_corr_valid;

  assign w_accept = bus.in_valid & r_in_ready;

  fine_sync_delay_ram #(
    .DEPTH (LAG),
    .WIDTH (2 * DATA_W),
    .AW    (AW)
  ) u_delay (
    .i_clk   (ap_clk),
    .i_en    (w_accept),
    .i_addr  (r_wr_ptr),
    .i_wdata ({bus.in_re, bus.in_im}),
    .o_rdata (w_rdata)
  );

  assign w_b_re = w_rdata[2*DATA_W-1:DATA_W];
  assign w_b_im = w_rdata[DATA_W-1:0];

  // state register; in_ready is registered from the next state so it never
  // depends combinationally on in_valid
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_FILL) || (w_next == ST_ACCUM);
    end
  end

  // FLUSH waits until stage 1 is empty: the product of the last sample
  // lands in r_p_* one edge later and is accumulated on the exit edge.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_FILL;
      ST_FILL:  if (w_accept && r_cnt == CNT_W'(LAG - 1)) w_next = ST_ACCUM;
      ST_ACCUM: if (w_accept && r_cnt == CNT_W'(WIN - 1)) w_next = ST_FLUSH;
      ST_FLUSH: if (!r_s1_vld) w_next = ST_DONE;
      ST_DONE:  if (bus.corr_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_corr_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (bus.start) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == ST_FILL && r_cnt == CNT_W'(LAG - 1)) r_cnt <= '0;
      else                                                 r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_rr   = r_a_re * w_b_re;
  assign w_ii   = r_a_im * w_b_im;
  assign w_ir   = r_a_im * w_b_re;
  assign w_ri   = r_a_re * w_b_im;
  assign w_p_re = PW'(w_rr) + PW'(w_ii);
  assign w_p_im = PW'(w_ir) - PW'(w_ri);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_a_re   <= '0;
      r_a_im   <= '0;
      r_s1_vld <= 1'b0;
      r_p_re   <= '0;
      r_p_im   <= '0;
      r_p_vld  <= 1'b0;
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else begin
      r_s1_vld <= w_accept && (r_state == ST_ACCUM);
      if (w_accept) begin
        r_a_re <= bus.in_re;
        r_a_im <= bus.in_im;
      end
      r_p_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_p_re <= w_p_re;
        r_p_im <= w_p_im;
      end
      if (r_state == ST_IDLE && bus.start) begin
        r_acc_re <= '0;
        r_acc_im <= '0;
      end else if (r_p_vld) begin
        r_acc_re <= r_acc_re + ACC_W'(r_p_re);
        r_acc_im <= r_acc_im + ACC_W'(r_p_im);
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.corr_re    = r_acc_re;
  assign bus.corr_im    = r_acc_im;
  assign bus.corr_valid = w_corr_valid;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_fine_sync_lag_correlator.sv
module tb_fine_sync_lag_correlator;
  import fine_sync_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  fine_sync_lag_correlator_if #(.DATA_W(FS_DATA_W), .ACC_W(FS_ACC_W)) bus ();

  fine_sync_lag_correlator #(
    .DATA_W (FS_DATA_W),
    .LAG    (FS_LAG),
    .WIN    (FS_WIN),
    .ACC_W  (FS_ACC_W)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge ap_clk) cyc = cyc + 1;

  typedef struct {
    longint      re;
    longint      im;
    int unsigned due;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic prev_valid = 1'b0;
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.corr_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", longint'(q.size()), 1);
        end else begin
          if (!prev_valid) check("latency", longint'(cyc), longint'(q[0].due));
          check("corr_re", longint'(bus.corr_re), q[0].re);
          check("corr_im", longint'(bus.corr_im), q[0].im);
          check("busy_in_done", longint'(bus.busy), 1);
          if (bus.corr_ready) void'(q.pop_front());
        end
      end
      prev_valid = bus.corr_valid;
    end
  end

  task automatic do_start(input int unsigned lat, input longint re, input longint im,
                          input bit push);
    bus.start = 1'b1;
    if (push) q.push_back('{re: re, im: im, due: cyc + lat});
    @(posedge ap_clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int re, input int im, input bit gap);
    int unsigned t;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge ap_clk); #1;
    end
    bus.in_re    = FS_DATA_W'(re);
    bus.in_im    = FS_DATA_W'(im);
    bus.in_valid = 1'b1;
    t = 0;
    @(negedge ap_clk);
    while (!bus.in_ready && t < 1000) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 1000) check("in_ready_timeout", longint'(t), 0);
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge ap_clk);
      t++;
    end
    if (q.size() != 0) begin
      check("result_timeout", longint'(q.size()), 0);
      q.delete();
    end
    #1;
  endtask

  task automatic run(input int unsigned lat, input longint re, input longint im,
                     input int r1, input int i1, input int r2, input int i2,
                     input bit gap);
    do_start(lat, re, im, 1'b1);
    for (int unsigned k = 0; k < FS_LAG; k++) send(r1, i1, gap);
    for (int unsigned k = 0; k < FS_WIN; k++) send(r2, i2, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   longint'(bus.in_ready),   0);
    check({tag, "_corr_valid"}, longint'(bus.corr_valid), 0);
    check({tag, "_corr_re"},    longint'(bus.corr_re),    0);
    check({tag, "_corr_im"},    longint'(bus.corr_im),    0);
    check({tag, "_busy"},       longint'(bus.busy),       0);
  endtask

  initial begin
    int unsigned t;
    ap_rst         = 1'b1;
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_re      = '0;
    bus.in_im      = '0;
    bus.corr_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_outputs("reset");
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // constant (1000,0)
    run(FS_LAG + FS_WIN + 3, 64_000_000, 0, 1000, 0, 1000, 0, 1'b0);
    wait_done();

    // (1000,0) then (0,1000): pure imaginary result
    run(FS_LAG + FS_WIN + 3, 0, 64_000_000, 1000, 0, 0, 1000, 1'b0);
    wait_done();

    // full-scale negative corner: 64 * 2^31 = 2^37
    run(FS_LAG + FS_WIN + 3, 64'sd137_438_953_472, 0, -32768, -32768, -32768, -32768, 1'b0);
    wait_done();

    // in_valid alternating 0-1-0-1
    run(2 * (FS_LAG + FS_WIN) + 3, 64_000_000, 0, 1000, 0, 1000, 0, 1'b1);
    wait_done();

    // result held with corr_ready low; starts in DONE are ignored
    // a=(300,50), b=(100,-200): p=(20000, 65000) per sample
    bus.corr_ready = 1'b0;
    run(FS_LAG + FS_WIN + 3, 1_280_000, 4_160_000, 100, -200, 300, 50, 1'b0);
    t = 0;
    while (!bus.corr_valid && t < 100) begin
      @(posedge ap_clk); #1;
      t++;
    end
    check("hold_valid_seen", longint'(bus.corr_valid), 1);
    repeat (10) @(posedge ap_clk);
    #1;
    check("hold_valid_high", longint'(bus.corr_valid), 1);
    bus.start = 1'b1;
    @(posedge ap_clk); #1;
    bus.start = 1'b0;
    check("start_in_done_busy", longint'(bus.busy), 1);
    check("start_in_done_valid", longint'(bus.corr_valid), 1);
    bus.corr_ready = 1'b1;
    bus.start      = 1'b1;   // coincides with DONE->IDLE, must be ignored
    @(posedge ap_clk); #1;
    bus.start = 1'b0;
    check("release_busy", longint'(bus.busy), 0);
    check("release_valid", longint'(bus.corr_valid), 0);
    repeat (3) @(posedge ap_clk);
    #1;
    check("idle_stays_busy", longint'(bus.busy), 0);
    check("idle_stays_in_ready", longint'(bus.in_ready), 0);
    check("queue_drained", longint'(q.size()), 0);

    // reset in the middle of ACCUM (at the 30th accumulate sample)
    do_start(0, 0, 0, 1'b0);
    for (int unsigned k = 0; k < FS_LAG + 29; k++) send(1000, 0, 1'b0);
    bus.in_re    = 16'sd1000;
    bus.in_im    = '0;
    bus.in_valid = 1'b1;
    ap_rst       = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    check_reset_outputs("midrun_reset");
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    run(FS_LAG + FS_WIN + 3, 64_000_000, 0, 1000, 0, 1000, 0, 1'b0);
    wait_done();

    repeat (2) @(posedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
